// File: rtl/spi_slave.sv
// spi_slave
//   SPI mode-0 slave front end running entirely in the clk6x domain. The SPI
//   pins are oversampled, received bytes are assembled MSB first and flagged
//   as header (first byte of a chip-select frame) or data byte, and a single
//   byte transmit buffer is shifted out on MISO.
//
// Ports
//   clk6x            system clock, rising edge
//   reset            synchronous, active-high reset
//   spi_clk_i        SCK pin (async, idle low)
//   spi_csn_i        chip select pin (async, active low)
//   spi_mosi_i       MOSI pin (async)
//   spi_miso_o       MISO data, MSB of the tx shift register
//   spi_miso_drive_o MISO output enable, high while synchronized CSn is low
//   rx_byte_o        last completed received byte
//   rx_hdr_en_o      one-cycle pulse: first byte of the frame completed
//   rx_db_en_o       one-cycle pulse: later byte of the frame completed
//   tx_byte_i        response byte
//   tx_en_i          strobe capturing tx_byte_i (only between bytes)

module spi_slave (
    input  logic       clk6x,
    input  logic       reset,
    input  logic       spi_clk_i,
    input  logic       spi_csn_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_drive_o,
    output logic [7:0] rx_byte_o,
    output logic       rx_hdr_en_o,
    output logic       rx_db_en_o,
    input  logic [7:0] tx_byte_i,
    input  logic       tx_en_i
);

    // [0],[1] synchronize; [2] is the previous synchronized value for edges.
    logic [2:0] sck_q,  sck_d;
    logic [2:0] csn_q,  csn_d;
    logic [2:0] mosi_q, mosi_d;

    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_byte_q,  rx_byte_d;
    logic       first_q,    first_d;
    logic       hdr_q,      hdr_d;
    logic       db_q,       db_d;

    logic       sck_rise;
    logic       sck_fall;
    logic       csn_high;
    logic       csn_rise;
    logic       mosi_bit;
    logic [7:0] rx_next;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign csn_high = csn_q[1];
    assign csn_rise = csn_q[1] & ~csn_q[2];
    // MOSI runs through the same three-deep pipeline as SCK; it is stable
    // around the rising edge, so the oldest stage lines up with the edge.
    assign mosi_bit = mosi_q[2];
    assign rx_next  = {rx_shift_q[6:0], mosi_bit};

    always_comb begin
        sck_d      = {sck_q[1:0],  spi_clk_i};
        csn_d      = {csn_q[1:0],  spi_csn_i};
        mosi_d     = {mosi_q[1:0], spi_mosi_i};
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_byte_d  = rx_byte_q;
        first_d    = first_q;
        hdr_d      = 1'b0;
        db_d       = 1'b0;

        if (csn_high) begin
            // Idle / end of frame: drop any partial byte and rearm the header.
            bit_cnt_d  = 3'd0;
            rx_shift_d = 8'h00;
            first_d    = 1'b1;
            if (csn_rise) begin
                tx_shift_d = 8'h00;
            end else if (tx_en_i) begin
                tx_shift_d = tx_byte_i;
            end
        end else begin
            if (sck_rise) begin
                rx_shift_d = rx_next;
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_byte_d  = rx_next;
                    hdr_d      = first_q;
                    db_d       = ~first_q;
                    first_d    = 1'b0;
                    // Flush the leftover bit so an unanswered byte reads 0x00.
                    tx_shift_d = 8'h00;
                end
            end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end

            if (tx_en_i && (bit_cnt_q == 3'd0)) begin
                tx_shift_d = tx_byte_i;
            end
        end
    end

    always_ff @(posedge clk6x) begin
        if (reset) begin
            sck_q      <= 3'b000;
            csn_q      <= 3'b111;
            mosi_q     <= 3'b000;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            first_q    <= 1'b1;
            hdr_q      <= 1'b0;
            db_q       <= 1'b0;
        end else begin
            sck_q      <= sck_d;
            csn_q      <= csn_d;
            mosi_q     <= mosi_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_byte_q  <= rx_byte_d;
            first_q    <= first_d;
            hdr_q      <= hdr_d;
            db_q       <= db_d;
        end
    end

    assign spi_miso_o       = tx_shift_q[7];
    assign spi_miso_drive_o = ~csn_q[1];
    assign rx_byte_o        = rx_byte_q;
    assign rx_hdr_en_o      = hdr_q;
    assign rx_db_en_o       = db_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave
//   Directed bench for spi_slave. A bus-functional SPI master drives the pins
//   and captures MISO; expected rx flags/bytes and MISO bytes are queued when
//   stimulus is issued and popped by independent monitors. A small responder
//   answers each data byte with (header + byte).

module tb_spi_slave;

    logic       clk6x      = 1'b0;
    logic       reset      = 1'b1;
    logic       spi_clk_i  = 1'b0;
    logic       spi_csn_i  = 1'b1;
    logic       spi_mosi_i = 1'b0;
    logic       spi_miso_o;
    logic       spi_miso_drive_o;
    logic [7:0] rx_byte_o;
    logic       rx_hdr_en_o;
    logic       rx_db_en_o;
    logic [7:0] tx_byte_i;
    logic       tx_en_i;

    logic       stim_en   = 1'b0;
    logic [7:0] stim_byte = 8'h00;
    logic       resp_en   = 1'b0;
    logic [7:0] resp_byte = 8'h00;
    logic [7:0] hdr_byte  = 8'h00;

    assign tx_en_i   = stim_en | resp_en;
    assign tx_byte_i = stim_en ? stim_byte : resp_byte;

    spi_slave dut (
        .clk6x            (clk6x),
        .reset            (reset),
        .spi_clk_i        (spi_clk_i),
        .spi_csn_i        (spi_csn_i),
        .spi_mosi_i       (spi_mosi_i),
        .spi_miso_o       (spi_miso_o),
        .spi_miso_drive_o (spi_miso_drive_o),
        .rx_byte_o        (rx_byte_o),
        .rx_hdr_en_o      (rx_hdr_en_o),
        .rx_db_en_o       (rx_db_en_o),
        .tx_byte_i        (tx_byte_i),
        .tx_en_i          (tx_en_i)
    );

    always #5 clk6x = ~clk6x;

    typedef struct packed {
        logic       hdr;
        logic [7:0] data;
    } rx_exp_t;

    rx_exp_t    rx_q[$];
    logic [7:0] miso_q[$];
    rx_exp_t    mon_e;
    logic [7:0] miso_obs;
    logic [7:0] miso_e;
    event       miso_ev;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // rx flag monitor
    always @(negedge clk6x) begin
        if (rx_hdr_en_o || rx_db_en_o) begin
            n_vec++;
            if (rx_hdr_en_o && rx_db_en_o) begin
                n_err++;
                $display("FAIL rx_flags: both hdr and db high, byte 0x%02h", rx_byte_o);
            end else if (rx_q.size() == 0) begin
                n_err++;
                $display("FAIL rx_unexpected: hdr=%b db=%b byte 0x%02h, none expected",
                         rx_hdr_en_o, rx_db_en_o, rx_byte_o);
            end else begin
                mon_e = rx_q.pop_front();
                if (mon_e.hdr !== rx_hdr_en_o || mon_e.data !== rx_byte_o) begin
                    n_err++;
                    $display("FAIL rx_byte: got hdr=%b byte 0x%02h expected hdr=%b byte 0x%02h",
                             rx_hdr_en_o, rx_byte_o, mon_e.hdr, mon_e.data);
                end
            end
        end
    end

    // MISO monitor, fed by the master model once per completed byte
    always @(miso_ev) begin
        n_vec++;
        if (miso_q.size() == 0) begin
            n_err++;
            $display("FAIL miso_unexpected: got 0x%02h, none expected", miso_obs);
        end else begin
            miso_e = miso_q.pop_front();
            if (miso_obs !== miso_e) begin
                n_err++;
                $display("FAIL miso_byte: got 0x%02h expected 0x%02h", miso_obs, miso_e);
            end
        end
    end

    // Responder: answers each data byte with header + byte, one cycle strobe.
    always @(negedge clk6x) begin
        resp_en = 1'b0;
        if (rx_hdr_en_o) hdr_byte = rx_byte_o;
        if (rx_db_en_o) begin
            resp_byte = hdr_byte + rx_byte_o;
            resp_en   = 1'b1;
        end
    end

    // Mode-0 master: MOSI set while SCK low, MISO sampled just before rise.
    task automatic send_bits(input logic [7:0] b, input int nbits);
        logic [7:0] obs;
        obs = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = b[7-i];
            repeat (8) @(negedge clk6x);
            obs = {obs[6:0], spi_miso_o};
            spi_clk_i = 1'b1;
            repeat (8) @(negedge clk6x);
            spi_clk_i = 1'b0;
        end
        if (nbits == 8) begin
            miso_obs = obs;
            -> miso_ev;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input logic hdr, input logic [7:0] miso_exp);
        rx_q.push_back({hdr, b});
        miso_q.push_back(miso_exp);
        send_bits(b, 8);
    endtask

    task automatic csn_low();
        spi_csn_i = 1'b0;
        repeat (8) @(negedge clk6x);
    endtask

    task automatic csn_high();
        spi_csn_i = 1'b1;
        repeat (8) @(negedge clk6x);
    endtask

    initial begin
        repeat (20) @(negedge clk6x);
        reset = 1'b0;
        repeat (2) @(negedge clk6x);
        check_bit ("rst_miso",  spi_miso_o,       1'b0);
        check_bit ("rst_drive", spi_miso_drive_o, 1'b0);
        check_byte("rst_rx",    rx_byte_o,        8'h00);
        check_bit ("rst_hdr",   rx_hdr_en_o,      1'b0);
        check_bit ("rst_db",    rx_db_en_o,       1'b0);

        // Frame A: header then four data bytes, responder echoes hdr+byte
        spi_csn_i = 1'b0;
        repeat (4) @(negedge clk6x);
        check_bit("drive_on_a", spi_miso_drive_o, 1'b1);
        repeat (4) @(negedge clk6x);
        xfer(8'h01, 1'b1, 8'h00);
        xfer(8'h20, 1'b0, 8'h00);
        xfer(8'h80, 1'b0, 8'h21);
        xfer(8'hA5, 1'b0, 8'h81);
        xfer(8'hC4, 1'b0, 8'hA6);
        repeat (4) @(negedge clk6x);
        check_byte("rx_hold_a", rx_byte_o, 8'hC4);
        spi_csn_i = 1'b1;
        repeat (4) @(negedge clk6x);
        check_bit("drive_off_a", spi_miso_drive_o, 1'b0);
        repeat (8) @(negedge clk6x);

        // Frame B: aborted after 4 bits, nothing published
        csn_low();
        send_bits(8'hF0, 4);
        spi_csn_i = 1'b1;
        repeat (6) @(negedge clk6x);
        check_bit ("drive_off_b", spi_miso_drive_o, 1'b0);
        check_byte("rx_hold_b",   rx_byte_o,        8'hC4);
        repeat (8) @(negedge clk6x);

        // Frame C: header flag rearmed after abort
        csn_low();
        xfer(8'h7E, 1'b1, 8'h00);
        xfer(8'h99, 1'b0, 8'h00);
        csn_high();

        // Preload while CSn high, then frame D transmits it first
        stim_byte = 8'h55;
        stim_en   = 1'b1;
        @(negedge clk6x);
        stim_en   = 1'b0;
        repeat (4) @(negedge clk6x);
        csn_low();
        xfer(8'h3C, 1'b1, 8'h55);
        csn_high();

        // Frame E: reset in the middle of a byte
        csn_low();
        send_bits(8'hFF, 3);
        reset = 1'b1;
        @(negedge clk6x);
        check_bit ("mrst_miso",  spi_miso_o,       1'b0);
        check_bit ("mrst_drive", spi_miso_drive_o, 1'b0);
        check_byte("mrst_rx",    rx_byte_o,        8'h00);
        check_bit ("mrst_hdr",   rx_hdr_en_o,      1'b0);
        check_bit ("mrst_db",    rx_db_en_o,       1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk6x);
        check_bit("drive_on_e", spi_miso_drive_o, 1'b1);
        repeat (4) @(negedge clk6x);
        xfer(8'h42, 1'b1, 8'h00);
        csn_high();

        repeat (10) @(negedge clk6x);
        check_byte("rx_left",   8'(rx_q.size()),   8'd0);
        check_byte("miso_left", 8'(miso_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
